// File: rtl/life_window_gen.sv
// life_window_gen: streaming 3x3 Game-of-Life neighbourhood generator, one raster-order cell per input handshake.
// Latency: the window for cell j is registered on the edge that accepts cell j+WIDTH+1; the last WIDTH+1 windows are flushed in DRAIN.
// Backpressure: in_ready is high only while the output register is free or being consumed, and is held low throughout DRAIN.
// Optional feature macro LIFE_WIN_SOF_EN: adds in_sof, which restarts the frame at cell (0,0) on any accepted input.
module life_window_gen #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int CW     = $clog2(WIDTH),
  parameter int RW     = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_cell,
`ifdef LIFE_WIN_SOF_EN
  input  logic          in_sof,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic          Tl,
  output logic          T,
  output logic          Tr,
  output logic          L,
  output logic          R,
  output logic          Bl,
  output logic          B,
  output logic          Br,
  output logic          C,
  output logic [CW-1:0] out_x,
  output logic [RW-1:0] out_y,
  output logic          out_last
);

  // History depth: the window of cell j spans cells j-WIDTH-1 .. j+WIDTH+1.
  // The newest of those (Br) is the cell arriving this cycle, so only
  // 2*WIDTH+2 past cells need to be kept.
  localparam int SRW = 2 * WIDTH + 2;
  localparam logic [CW-1:0] X_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] Y_LAST = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  // sr[i] holds the cell accepted i+1 handshakes ago (sr[0] = previous cell)
  logic [SRW-1:0] sr;

  // Position of the next input cell and of the next window to be loaded
  logic [CW-1:0] ix, nx;
  logic [RW-1:0] iy, ny;

  logic in_acc, out_hs, sof_hit;
  logic load_run, load_drain, load, drain_done;
  logic in_is_lag, in_is_last;

  logic first_col, last_col, top_row, bot_row, new_cell;
  logic w_tl, w_t, w_tr, w_l, w_c, w_r, w_bl, w_b, w_br;

  // Input index D-1 = WIDTH is cell (0,1); input N-1 is the bottom-right cell
  assign in_is_lag  = (ix == '0) && (iy == RW'(1));
  assign in_is_last = (ix == X_LAST) && (iy == Y_LAST);
  assign load       = load_run || load_drain;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: FILL collects the lag, RUN streams, DRAIN flushes the bottom rows
  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:    if (in_acc && in_is_lag)  state_nxt = RUN;
      RUN:     if (in_acc && in_is_last) state_nxt = DRAIN;
      DRAIN:   if (drain_done)           state_nxt = FILL;
      default:                           state_nxt = FILL;
    endcase
    // An explicit start-of-frame always restarts collection
    if (sof_hit) state_nxt = FILL;
  end

  // FSM outputs: handshake qualifiers and window-load strobes
  always_comb begin
    in_ready   = (state != DRAIN) && (!out_valid || out_ready);
    in_acc     = in_valid && in_ready;
    out_hs     = out_valid && out_ready;
`ifdef LIFE_WIN_SOF_EN
    sof_hit    = in_acc && in_sof;
`else
    sof_hit    = 1'b0;
`endif
    load_run   = in_acc && (state == RUN) && !sof_hit;
    // In DRAIN the output register refills whenever it is free, until the
    // last window of the frame has been loaded (out_last then stays high)
    load_drain = (state == DRAIN) && (!out_valid || out_ready) && !out_last;
    drain_done = (state == DRAIN) && out_hs && out_last;
  end

  // Window assembly for the cell at (nx,ny) from history plus the arriving cell, with border masking
  always_comb begin
    first_col = (nx == '0);
    last_col  = (nx == X_LAST);
    top_row   = (ny == '0);
    bot_row   = (ny == Y_LAST);
    // Positions beyond the end of the frame are dead cells
    new_cell  = (state == DRAIN) ? 1'b0 : in_cell;

    w_tl = sr[2*WIDTH+1] & ~top_row & ~first_col;
    w_t  = sr[2*WIDTH]   & ~top_row;
    w_tr = sr[2*WIDTH-1] & ~top_row & ~last_col;
    w_l  = sr[WIDTH+1]   & ~first_col;
    w_c  = sr[WIDTH];
    w_r  = sr[WIDTH-1]   & ~last_col;
    w_bl = sr[1]         & ~bot_row & ~first_col;
    w_b  = sr[0]         & ~bot_row;
    w_br = new_cell      & ~bot_row & ~last_col;
  end

  // Cell history and input position: shift on every accepted cell, shift in a dead cell per drain step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
      ix <= '0;
      iy <= '0;
    end else if (sof_hit) begin
      // The start-of-frame cell becomes cell (0,0); older history is discarded
      sr <= {{(SRW-1){1'b0}}, in_cell};
      ix <= CW'(1);
      iy <= '0;
    end else begin
      if (in_acc) begin
        sr <= {sr[SRW-2:0], in_cell};
        // Wraps to (0,0) after the last cell, ready for the next frame
        if (ix == X_LAST) begin
          ix <= '0;
          iy <= (iy == Y_LAST) ? '0 : iy + RW'(1);
        end else begin
          ix <= ix + CW'(1);
        end
      end else if (load_drain) begin
        sr <= {sr[SRW-2:0], 1'b0};
      end
    end
  end

  // Output register and next-window position; contents hold while out_valid && !out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Tl        <= 1'b0;
      T         <= 1'b0;
      Tr        <= 1'b0;
      L         <= 1'b0;
      C         <= 1'b0;
      R         <= 1'b0;
      Bl        <= 1'b0;
      B         <= 1'b0;
      Br        <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_last  <= 1'b0;
      nx        <= '0;
      ny        <= '0;
    end else if (sof_hit) begin
      // A pending window belongs to the abandoned frame
      out_valid <= 1'b0;
      nx        <= '0;
      ny        <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      Tl        <= w_tl;
      T         <= w_t;
      Tr        <= w_tr;
      L         <= w_l;
      C         <= w_c;
      R         <= w_r;
      Bl        <= w_bl;
      B         <= w_b;
      Br        <= w_br;
      out_x     <= nx;
      out_y     <= ny;
      out_last  <= last_col && bot_row;
      // Wraps to (0,0) after the last window of the frame
      if (nx == X_LAST) begin
        nx <= '0;
        ny <= (ny == Y_LAST) ? '0 : ny + RW'(1);
      end else begin
        nx <= nx + CW'(1);
      end
    end else if (out_hs) begin
      out_valid <= 1'b0;
    end
  end

endmodule
